// File: rtl/tdc_coarse_counter.sv
// tdc_coarse_counter
// Coarse time-to-digital counter: measures how many whole clk cycles an
// asynchronous pulse stays high and hands the result downstream with a
// valid/ready handshake.
// Optional feature macro: TDC_COARSE_TIMEOUT_EN. When defined, a pulse still
// high after TIMEOUT_CYC cycles is reported immediately as an overflow result.
// When undefined, overflow_o is raised only by counter saturation.
module tdc_coarse_counter #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 16'hFFF0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pulse_i,
  input  logic             enable_i,
  input  logic             ready_i,
  output logic [CNT_W-1:0] count_o,
  output logic             valid_o,
  output logic             overflow_o,
  output logic             missed_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNT    = 2'd1,
    HOLD     = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

`ifdef TDC_COARSE_TIMEOUT_EN
  localparam bit TIMEOUT_ACTIVE = 1'b1;
`else
  localparam bit TIMEOUT_ACTIVE = 1'b0;
`endif

  // sync_reg[0], sync_reg[1]: two-flop synchronizer; sync_reg[2]: edge-detect history
  logic [2:0]       sync_reg;
  // settle_reg fills with ones after reset release; once sync_reg[1] reflects
  // the real input, a low level arms edge detection. This keeps a pulse that
  // was already high across reset from being measured.
  logic [1:0]       settle_reg;
  logic             armed_reg;

  logic             pulse_s;
  logic             pulse_d;
  logic             rise;
  logic             fall;
  logic             accept;
  logic             timeout_hit;

  state_t           state_reg,     state_next;
  logic [CNT_W-1:0] counter_reg,   counter_next;
  logic             sat_reg,       sat_next;
  logic [CNT_W-1:0] count_reg,     count_next;
  logic             ovf_reg,       ovf_next;
  logic             valid_reg,     valid_next;
  logic             missed_reg,    missed_next;
  logic             timed_out_reg, timed_out_next;

  // Synchronize the asynchronous pulse and track whether edges may be trusted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg   <= 3'b000;
      settle_reg <= 2'b00;
      armed_reg  <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[1:0], pulse_i};
      settle_reg <= {settle_reg[0], 1'b1};
      armed_reg  <= armed_reg | (settle_reg[1] & ~sync_reg[1]);
    end
  end

  assign pulse_s     = sync_reg[1];
  assign pulse_d     = sync_reg[2];
  assign rise        = armed_reg & pulse_s & ~pulse_d;
  assign fall        = pulse_d & ~pulse_s;
  assign accept      = valid_reg & ready_i;
  assign timeout_hit = TIMEOUT_ACTIVE && (counter_reg == TIMEOUT_VAL);

  // Next-state and datapath decisions for the measurement FSM.
  always_comb begin
    state_next     = state_reg;
    counter_next   = counter_reg;
    sat_next       = sat_reg;
    count_next     = count_reg;
    ovf_next       = ovf_reg;
    valid_next     = valid_reg;
    missed_next    = missed_reg;
    timed_out_next = timed_out_reg;

    case (state_reg)
      IDLE: begin
        if (rise && enable_i) begin
          state_next   = COUNT;
          counter_next = CNT_ONE;
          sat_next     = 1'b0;
        end
      end

      COUNT: begin
        if (!enable_i) begin
          // Measurement abandoned; let the pulse finish without a result.
          state_next = WAIT_LOW;
        end else if (fall) begin
          count_next     = counter_reg;
          ovf_next       = sat_reg;
          valid_next     = 1'b1;
          timed_out_next = 1'b0;
          state_next     = HOLD;
        end else if (timeout_hit) begin
          // Pulse still high at the timeout: report now, skip the rest of it.
          count_next     = counter_reg;
          ovf_next       = 1'b1;
          valid_next     = 1'b1;
          timed_out_next = 1'b1;
          state_next     = HOLD;
        end else if (counter_reg == CNT_MAX) begin
          sat_next = 1'b1;
        end else begin
          counter_next = counter_reg + CNT_ONE;
        end
      end

      HOLD: begin
        if (accept) begin
          valid_next = 1'b0;
          if (rise && enable_i) begin
            // A new pulse starting exactly at hand-off is still measured.
            state_next   = COUNT;
            counter_next = CNT_ONE;
            sat_next     = 1'b0;
          end else if (timed_out_reg) begin
            state_next = WAIT_LOW;
          end else begin
            state_next = IDLE;
          end
        end else if (rise) begin
          missed_next = 1'b1;
        end
      end

      WAIT_LOW: begin
        if (!pulse_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counter and result registers; reset discards any measurement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      counter_reg   <= '0;
      sat_reg       <= 1'b0;
      count_reg     <= '0;
      ovf_reg       <= 1'b0;
      valid_reg     <= 1'b0;
      missed_reg    <= 1'b0;
      timed_out_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      counter_reg   <= counter_next;
      sat_reg       <= sat_next;
      count_reg     <= count_next;
      ovf_reg       <= ovf_next;
      valid_reg     <= valid_next;
      missed_reg    <= missed_next;
      timed_out_reg <= timed_out_next;
    end
  end

  assign count_o    = count_reg;
  assign valid_o    = valid_reg;
  assign overflow_o = ovf_reg;
  assign missed_o   = missed_reg;
  assign busy_o     = (state_reg != IDLE);

endmodule

// File: tb/tb_tdc_coarse_counter.sv
// tb_tdc_coarse_counter
// Scoreboard bench: expected {overflow, count} pairs are queued when a pulse is
// driven and compared when valid_o rises. Instance a uses default parameters,
// instance b uses CNT_W=4 / TIMEOUT_CYC=8. Honours TDC_COARSE_TIMEOUT_EN.
module tb_tdc_coarse_counter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable_i;
  logic        ready_i;
  logic        pulse_a;
  logic        pulse_b;

  logic [15:0] count_a;
  logic        valid_a, ovf_a, missed_a, busy_a;
  logic [3:0]  count_b;
  logic        valid_b, ovf_b, missed_b, busy_b;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          vcnt;
  bit          to_en;

  logic [16:0] sb_a[$];
  logic [16:0] sb_b[$];
  logic [16:0] e_a, e_b, held_a, held_b;
  logic        va_prev = 1'b0;
  logic        vb_prev = 1'b0;
  bit          track_a = 1'b0;
  bit          track_b = 1'b0;

  int lens_a[7] = '{1, 2, 3, 7, 15, 16, 33};
  int lens_b[4] = '{5, 12, 15, 16};

  always #5 clk = ~clk;

  tdc_coarse_counter dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .pulse_i    (pulse_a),
    .enable_i   (enable_i),
    .ready_i    (ready_i),
    .count_o    (count_a),
    .valid_o    (valid_a),
    .overflow_o (ovf_a),
    .missed_o   (missed_a),
    .busy_o     (busy_a)
  );

  tdc_coarse_counter #(.CNT_W(4), .TIMEOUT_CYC(8)) dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .pulse_i    (pulse_b),
    .enable_i   (enable_i),
    .ready_i    (ready_i),
    .count_o    (count_b),
    .valid_o    (valid_b),
    .overflow_o (ovf_b),
    .missed_o   (missed_b),
    .busy_o     (busy_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference behaviour: count = pulse length, clipped by timeout or saturation.
  function automatic logic [16:0] model(input int len, input int w, input int t);
    int maxv;
    maxv = (1 << w) - 1;
    if (to_en && len > t) return {1'b1, t[15:0]};
    if (len > maxv) return {1'b1, maxv[15:0]};
    return {1'b0, len[15:0]};
  endfunction

  task automatic drive_pulse(input bit on_b, input int n);
    @(posedge clk);
    #2;
    if (on_b) pulse_b = 1'b1; else pulse_a = 1'b1;
    repeat (n) @(posedge clk);
    #2;
    if (on_b) pulse_b = 1'b0; else pulse_a = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((sb_a.size() + sb_b.size()) != 0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    if ((sb_a.size() + sb_b.size()) != 0)
      check("result_wait", sb_a.size() + sb_b.size(), 0);
    repeat (6) @(posedge clk);
  endtask

  // Monitor for instance a: pop on valid rise, then demand a stable result.
  always @(negedge clk) begin
    if (valid_a && !va_prev) begin
      if (sb_a.size() == 0) begin
        check("a_unexpected_result", 1, 0);
        track_a = 1'b0;
      end else begin
        e_a = sb_a.pop_front();
        $display("a result: count=%0d ovf=%0d (expected count=%0d ovf=%0d)",
                 count_a, ovf_a, e_a[15:0], e_a[16]);
        check("a_count", int'(count_a), int'(e_a[15:0]));
        check("a_overflow", int'(ovf_a), int'(e_a[16]));
        held_a  = e_a;
        track_a = 1'b1;
      end
    end else if (valid_a && track_a) begin
      check("a_hold_stable", int'({ovf_a, count_a}), int'(held_a));
    end
    va_prev = valid_a;
  end

  // Monitor for instance b.
  always @(negedge clk) begin
    if (valid_b && !vb_prev) begin
      if (sb_b.size() == 0) begin
        check("b_unexpected_result", 1, 0);
        track_b = 1'b0;
      end else begin
        e_b = sb_b.pop_front();
        $display("b result: count=%0d ovf=%0d (expected count=%0d ovf=%0d)",
                 count_b, ovf_b, e_b[15:0], e_b[16]);
        check("b_count", int'(count_b), int'(e_b[15:0]));
        check("b_overflow", int'(ovf_b), int'(e_b[16]));
        held_b  = e_b;
        track_b = 1'b1;
      end
    end else if (valid_b && track_b) begin
      check("b_hold_stable", int'({ovf_b, 12'd0, count_b}), int'(held_b));
    end
    vb_prev = valid_b;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
`ifdef TDC_COARSE_TIMEOUT_EN
    to_en = 1'b1;
`else
    to_en = 1'b0;
`endif
    reset_n  = 1'b0;
    enable_i = 1'b1;
    ready_i  = 1'b1;
    pulse_a  = 1'b0;
    pulse_b  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_count",    int'(count_a),  0);
    check("rst_valid",    int'(valid_a),  0);
    check("rst_overflow", int'(ovf_a),    0);
    check("rst_missed",   int'(missed_a), 0);
    check("rst_busy",     int'(busy_a),   0);
    check("rst_b_busy",   int'(busy_b),   0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (5) @(posedge clk);

    // 10-cycle pulse, ready high: one result, valid for exactly one cycle
    sb_a.push_back(model(10, 16, 32'hFFF0));
    @(posedge clk);
    #2 pulse_a = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("busy_counting", int'(busy_a), 1);
    repeat (5) @(posedge clk);
    #2 pulse_a = 1'b0;
    vcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid_a) vcnt++;
    end
    check("valid_one_cycle", vcnt, 1);
    drain();
    @(negedge clk);
    check("idle_after_result", int'(busy_a), 0);

    // Assorted lengths
    foreach (lens_a[i]) begin
      sb_a.push_back(model(lens_a[i], 16, 32'hFFF0));
      drive_pulse(1'b0, lens_a[i]);
      drain();
    end

    // Result pending: second pulse dropped and flagged
    ready_i = 1'b0;
    sb_a.push_back(model(5, 16, 32'hFFF0));
    drive_pulse(1'b0, 5);
    repeat (6) @(posedge clk);
    drive_pulse(1'b0, 3);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pending_count",  int'(count_a),  5);
    check("pending_valid",  int'(valid_a),  1);
    check("pending_missed", int'(missed_a), 1);
    @(posedge clk);
    #2 ready_i = 1'b1;
    @(negedge clk);
    check("valid_until_accept", int'(valid_a), 1);
    @(negedge clk);
    check("valid_fall_after_accept", int'(valid_a), 0);
    drain();
    sb_a.push_back(model(4, 16, 32'hFFF0));
    drive_pulse(1'b0, 4);
    drain();
    check("missed_sticky", int'(missed_a), 1);

    // enable dropped during COUNT aborts the measurement
    @(posedge clk);
    #2 pulse_a = 1'b1;
    repeat (3) @(posedge clk);
    #2 enable_i = 1'b0;
    repeat (7) @(posedge clk);
    #2 pulse_a = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("abort_idle", int'(busy_a), 0);
    check("abort_no_valid", int'(valid_a), 0);
    @(posedge clk);
    #2 enable_i = 1'b1;
    sb_a.push_back(model(6, 16, 32'hFFF0));
    drive_pulse(1'b0, 6);
    drain();

    // Reset during COUNT discards the pulse, even after release
    @(posedge clk);
    #2 pulse_a = 1'b1;
    repeat (8) @(posedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    check("midrst_count",    int'(count_a),  0);
    check("midrst_valid",    int'(valid_a),  0);
    check("midrst_overflow", int'(ovf_a),    0);
    check("midrst_missed",   int'(missed_a), 0);
    check("midrst_busy",     int'(busy_a),   0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("no_remeasure_busy", int'(busy_a), 0);
    repeat (7) @(posedge clk);
    #2 pulse_a = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("no_result_after_rst", int'(valid_a), 0);
    sb_a.push_back(model(4, 16, 32'hFFF0));
    drive_pulse(1'b0, 4);
    drain();

    // Narrow counter: saturation, or timeout when enabled
    ready_i = 1'b0;
    sb_b.push_back(model(20, 4, 8));
    @(posedge clk);
    #2 pulse_b = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("b_result_before_fall", int'(valid_b), int'(to_en));
    repeat (5) @(posedge clk);
    #2 pulse_b = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("b_result_pending", int'(valid_b), 1);
    ready_i = 1'b1;
    drain();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("b_no_second_result", int'(valid_b), 0);
    check("b_idle", int'(busy_b), 0);

    foreach (lens_b[i]) begin
      sb_b.push_back(model(lens_b[i], 4, 8));
      drive_pulse(1'b1, lens_b[i]);
      drain();
    end

    check("a_queue_empty", sb_a.size(), 0);
    check("b_queue_empty", sb_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
